bmem_arbiter: RTL and testbench

- Shares the single banked-memory port between the instruction cache and the data cache.
- Converts each granted 256-bit line request into a bmem transaction: one read command followed by four 64-bit return beats, or a four-beat write burst.
- Sits between the two caches' downward-facing ports and the banked memory.
- Blocking: one transaction in flight at a time.

---
 rtl/bmem_arb_pkg.sv | 24 ++
 rtl/bmem_line_buffer.sv | 41 ++++
 rtl/bmem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bmem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_arb_pkg.sv
// Shared constants and types for the icache/dcache banked-memory arbiter.
// Line geometry, FSM state and requester identity live here.
package bmem_arb_pkg;

   localparam int unsigned LINE_W      = 256;
   localparam int unsigned BEAT_W      = 64;
   localparam int unsigned BEATS       = LINE_W / BEAT_W;
   localparam int unsigned OFFSET_BITS = 5;
   localparam int unsigned CNT_W       = $clog2(BEATS);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_BURST,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_t;

endpackage

// File: rtl/bmem_line_buffer.sv
// One cacheline of storage plus the beat counter that walks it.
// Holds the writeback line for bursts and assembles return beats for fills.
module bmem_line_buffer #(
   parameter int unsigned LINE_W = bmem_arb_pkg::LINE_W,
   parameter int unsigned BEAT_W = bmem_arb_pkg::BEAT_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_en,
   input  logic [LINE_W-1:0]              load_data,
   input  logic                           beat_we,
   input  logic [BEAT_W-1:0]              beat_wdata,
   input  logic                           cnt_clr,
   input  logic                           cnt_inc,
   output logic [LINE_W-1:0]              line,
   output logic [bmem_arb_pkg::CNT_W-1:0] cnt,
   output logic [BEAT_W-1:0]              beat_rdata
);
   import bmem_arb_pkg::*;

   always_ff @(posedge clk) begin
      if (!rst) begin
         line <= '0;
         cnt  <= '0;
      end else begin
         if (load_en) begin
            line <= load_data;
         end else if (beat_we) begin
            line[BEAT_W*cnt +: BEAT_W] <= beat_wdata;
         end
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign beat_rdata = line[BEAT_W*cnt +: BEAT_W];

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter sharing one banked-memory port between icache and dcache.
// One line transaction at a time: a read command plus four return beats, or a four-beat write.
module bmem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = bmem_arb_pkg::LINE_W,
   parameter int unsigned BEAT_W = bmem_arb_pkg::BEAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [ADDR_W-1:0] bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);
   import bmem_arb_pkg::*;

   arb_state_t        state;
   arb_owner_t        owner_q;
   arb_owner_t        last_grant;

   logic              i_req;
   logic              d_req;
   logic              grant_any;
   logic              grant_d;
   logic              grant_wr;
   arb_owner_t        grant_owner;
   logic [ADDR_W-1:0] grant_addr;

   logic              load_en;
   logic              beat_we;
   logic              cnt_clr;
   logic              cnt_inc;
   logic [LINE_W-1:0] line;
   logic [CNT_W-1:0]  cnt;
   logic [BEAT_W-1:0] beat_rdata;
   logic              beat_hit;
   logic              last_beat;
   logic [LINE_W-1:0] fill_line;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      i_req       = i_read;
      d_req       = d_read | d_write;
      grant_any   = i_req | d_req;
      grant_d     = d_req & (~i_req | (last_grant == OWN_I));
      grant_wr    = grant_d & d_write;
      grant_owner = grant_d ? OWN_D : OWN_I;
      grant_addr  = grant_d ? d_addr : i_addr;
      grant_addr[OFFSET_BITS-1:0] = '0;
   end

   always_comb begin
      load_en   = 1'b0;
      beat_we   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      beat_hit  = bmem_rvalid && (bmem_raddr == bmem_addr);
      last_beat = (cnt == CNT_W'(BEATS - 1));
      unique case (state)
         IDLE: begin
            if (grant_any) begin
               cnt_clr = 1'b1;
               load_en = grant_wr;
            end
         end
         RD_WAIT: begin
            if (beat_hit) begin
               beat_we = 1'b1;
               cnt_clr = last_beat;
               cnt_inc = ~last_beat;
            end
         end
         WR_BURST: begin
            if (bmem_ready) begin
               cnt_clr = last_beat;
               cnt_inc = ~last_beat;
            end
         end
         default: ;
      endcase
   end

   // The last beat is written into the buffer on the same edge the fill is published,
   // so the published line splices it in directly.
   assign fill_line  = {bmem_rdata, line[LINE_W-BEAT_W-1:0]};
   assign bmem_wdata = bmem_write ? beat_rdata : '0;

   bmem_line_buffer #(
      .LINE_W (LINE_W),
      .BEAT_W (BEAT_W)
   ) u_line_buffer (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .load_data  (d_wdata),
      .beat_we    (beat_we),
      .beat_wdata (bmem_rdata),
      .cnt_clr    (cnt_clr),
      .cnt_inc    (cnt_inc),
      .line       (line),
      .cnt        (cnt),
      .beat_rdata (beat_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         owner_q    <= OWN_I;
         last_grant <= OWN_I;
         bmem_addr  <= '0;
         bmem_read  <= 1'b0;
         bmem_write <= 1'b0;
         i_resp     <= 1'b0;
         d_resp     <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_any) begin
                  owner_q    <= grant_owner;
                  last_grant <= grant_owner;
                  bmem_addr  <= grant_addr;
                  if (grant_wr) begin
                     bmem_write <= 1'b1;
                     state      <= WR_BURST;
                  end else begin
                     bmem_read  <= 1'b1;
                     state      <= RD_REQ;
                  end
               end
            end
            RD_REQ: begin
               if (bmem_ready) begin
                  bmem_read <= 1'b0;
                  state     <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (beat_hit && last_beat) begin
                  state <= RESP;
                  if (owner_q == OWN_D) begin
                     d_rdata <= fill_line;
                     d_resp  <= 1'b1;
                  end else begin
                     i_rdata <= fill_line;
                     i_resp  <= 1'b1;
                  end
               end
            end
            WR_BURST: begin
               if (bmem_ready && last_beat) begin
                  bmem_write <= 1'b0;
                  d_resp     <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               i_resp <= 1'b0;
               d_resp <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: a transaction-level model predicts every output each cycle,
// driven by directed cases and randomized traffic against a simple memory responder.
module tb_bmem_arbiter;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   i_addr = '0, d_addr = '0, bmem_addr, bmem_raddr;
   logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
   logic          i_resp, d_resp, bmem_read, bmem_write, bmem_ready, bmem_rvalid;
   logic [255:0]  i_rdata, d_rdata, d_wdata = '0;
   logic [63:0]   bmem_wdata, bmem_rdata;

   int            tests = 0;
   int            fails = 0;
   bit            chk_on = 1'b0;
   int unsigned   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bmem_arbiter #(
      .ADDR_W (32),
      .LINE_W (256),
      .BEAT_W (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_addr      (i_addr),
      .i_read      (i_read),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_addr      (d_addr),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   int unsigned ready_pct = 100;
   int unsigned gap_pct   = 0;
   int unsigned lo_start  = 0, lo_end = 0;
   int          rd_left   = 0;
   int          match_sent = 0;
   logic [31:0] rd_addr   = '0;
   bit          stray_en  = 1'b0, stray_next = 1'b1, use_force = 1'b0;
   logic [63:0] force_beat [4];

   initial begin
      bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (cyc >= lo_start && cyc < lo_end) bmem_ready = 1'b0;
         else bmem_ready = ($urandom_range(0, 99) < ready_pct);
         bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
         if (rd_left > 0 && $urandom_range(0, 99) >= gap_pct) begin
            bmem_rvalid = 1'b1;
            if (stray_en && stray_next) begin
               bmem_raddr = 32'hdead0000;
               bmem_rdata = {$urandom, $urandom};
               stray_next = 1'b0;
            end else begin
               bmem_raddr = rd_addr;
               bmem_rdata = use_force ? force_beat[4 - rd_left] : {$urandom, $urandom};
               rd_left--;
               match_sent++;
               stray_next = 1'b1;
            end
         end
         @(negedge clk);
         if (bmem_read && bmem_ready) begin
            rd_left = 4;
            rd_addr = bmem_addr;
         end
      end
   end

   // ---------------- transaction-level model + per-cycle compare ----------------
   bit           m_act = 0, m_resp = 0, m_wr = 0, m_own = 0, m_last = 0, m_cmd = 0;
   int           m_got = 0, m_widx = 0;
   logic [31:0]  m_addr = '0;
   logic [255:0] m_wline = '0, m_asm = '0, m_iline = '0, m_dline = '0;
   int           rd_cmds = 0, wcyc = 0;
   logic [63:0]  wq [$];

   always @(negedge clk) begin
      bit ireq, dreq;
      if (m_resp && !m_wr) begin
         if (m_own) m_dline = m_asm; else m_iline = m_asm;
      end
      if (chk_on) begin
         check("bmem_read", bmem_read, m_act && !m_wr && m_cmd);
         check("bmem_write", bmem_write, m_act && m_wr);
         check("rd_wr_exclusive", bmem_read && bmem_write, 1'b0);
         if (m_act) check("bmem_addr", bmem_addr, m_addr);
         check("bmem_wdata", bmem_wdata, (m_act && m_wr) ? m_wline[64*m_widx +: 64] : 64'd0);
         check("i_resp", i_resp, m_resp && !m_own);
         check("d_resp", d_resp, m_resp && m_own);
         check("i_rdata", i_rdata, m_iline);
         check("d_rdata", d_rdata, m_dline);
         if (bmem_read && bmem_ready) rd_cmds++;
         if (bmem_write) begin
            wcyc++;
            if (bmem_ready) wq.push_back(bmem_wdata);
         end
      end
      if (!rst) begin
         m_act = 0; m_resp = 0; m_last = 0; m_iline = '0; m_dline = '0;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_act) begin
         if (m_wr) begin
            if (bmem_ready) begin
               m_widx++;
               if (m_widx == 4) begin m_act = 0; m_resp = 1; end
            end
         end else if (m_cmd) begin
            if (bmem_ready) m_cmd = 0;
         end else if (bmem_rvalid && bmem_raddr == m_addr) begin
            m_asm[64*m_got +: 64] = bmem_rdata;
            m_got++;
            if (m_got == 4) begin m_act = 0; m_resp = 1; end
         end
      end else begin
         ireq = i_read;
         dreq = d_read || d_write;
         if (ireq || dreq) begin
            m_own   = (ireq && dreq) ? !m_last : dreq;
            m_last  = m_own;
            m_wr    = m_own && d_write;
            m_addr  = (m_own ? d_addr : i_addr) & 32'hffff_ffe0;
            m_wline = d_wdata;
            m_cmd   = !m_wr;
            m_got   = 0;
            m_widx  = 0;
            m_asm   = '0;
            m_act   = 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic run(input bit ie, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [255:0] wd,
                      input int unsigned lo_off, input int unsigned lo_len,
                      output int ni, output int nd);
      int n;
      bit iw, dwt, si, sd;
      n = 0; ni = 0; nd = 0;
      @(posedge clk); #1;
      if (lo_len > 0) begin lo_start = cyc + lo_off; lo_end = lo_start + lo_len; end
      i_read = ie; i_addr = ia; d_read = dr; d_write = dw; d_addr = da; d_wdata = wd;
      iw = ie; dwt = dr | dw;
      while ((iw || dwt) && n < 400) begin
         @(negedge clk); n++;
         si = i_resp; sd = d_resp;
         @(posedge clk); #1;
         if (si && iw)  begin i_read = 0; iw = 0; ni = n; end
         if (sd && dwt) begin d_read = 0; d_write = 0; dwt = 0; nd = n; end
      end
      if (iw || dwt) begin
         tests++; fails++;
         $display("FAIL resp_timeout: pending i=%0b d=%0b after %0d cycles, expected none", iw, dwt, n);
         i_read = 0; d_read = 0; d_write = 0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (rd_left > 0 && n < 200) begin @(posedge clk); #1; n++; end
      if (rd_left > 0) begin
         tests++; fails++;
         $display("FAIL drain: rd_left=%0d expected 0", rd_left);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk); #1;
      rst = 0; i_read = 0; d_read = 0; d_write = 0;
      repeat (cycles) begin @(posedge clk); #1; end
      rst = 1;
   endtask

   task automatic clear_mon();
      rd_cmds = 0; wcyc = 0; wq.delete();
   endtask

   // ---------------- main sequence ----------------
   logic [255:0] wl, exp_line;
   int ni, nd, base, n;

   initial begin
      force_beat[0] = 64'h1111_1111_1111_1111;
      force_beat[1] = 64'h2222_2222_2222_2222;
      force_beat[2] = 64'h3333_3333_3333_3333;
      force_beat[3] = 64'h4444_4444_4444_4444;
      exp_line = {force_beat[3], force_beat[2], force_beat[1], force_beat[0]};

      repeat (3) @(posedge clk);
      #1; rst = 1; chk_on = 1;
      @(negedge clk);
      check("reset_bmem_read", bmem_read, 1'b0);
      check("reset_bmem_write", bmem_write, 1'b0);
      check("reset_bmem_addr", bmem_addr, 32'h0);
      check("reset_resp", {i_resp, d_resp}, 2'b00);
      check("reset_rdata", i_rdata | d_rdata, 256'h0);

      // icache read with known beats
      use_force = 1; clear_mon();
      run(1, 32'h1eceb004, 0, 0, 32'h0, '0, 0, 0, ni, nd);
      check("rd_addr_aligned", rd_addr, 32'h1eceb000);
      check("rd_cmd_count", rd_cmds, 1);
      check("rd_latency", ni, 7);
      check("rd_line", i_rdata, exp_line);
      check("rd_d_untouched", d_rdata, 256'h0);

      // dcache write, memory always ready
      wl = {64'hd3d3_0000_0000_0003, 64'hd2d2_0000_0000_0002,
            64'hd1d1_0000_0000_0001, 64'hd0d0_0000_0000_0000};
      clear_mon();
      run(0, 32'h0, 0, 1, 32'h0000_1020, wl, 0, 0, ni, nd);
      check("wr_latency", nd, 6);
      check("wr_cycles", wcyc, 4);
      check("wr_beats", wq.size(), 4);
      for (int b = 0; b < 4 && b < wq.size(); b++) check("wr_beat", wq[b], wl[64*b +: 64]);

      // write with ready low on the 2nd and 3rd beat cycles
      clear_mon();
      run(0, 32'h0, 0, 1, 32'h0000_1020, wl, 2, 2, ni, nd);
      check("wr_stall_latency", nd, 8);
      check("wr_stall_cycles", wcyc, 6);
      check("wr_stall_beats", wq.size(), 4);
      for (int b = 0; b < 4 && b < wq.size(); b++) check("wr_stall_beat", wq[b], wl[64*b +: 64]);

      // ties: first after reset goes to D; I waits for the full D read
      use_force = 0;
      do_reset(1);
      run(1, 32'h0000_4000, 1, 0, 32'h0000_8000, '0, 0, 0, ni, nd);
      check("tie1_d_latency", nd, 7);
      check("tie1_i_latency", ni, 14);
      // a lone D grant leaves last_grant on D, so the next tie favours I
      run(0, 32'h0, 0, 1, 32'h0000_8040, wl, 0, 0, ni, nd);
      run(1, 32'h0000_4040, 1, 0, 32'h0000_8080, '0, 0, 0, ni, nd);
      check("tie2_i_latency", ni, 7);
      check("tie2_d_latency", nd, 14);

      // stray beats interleaved with the real ones
      use_force = 1; stray_en = 1; stray_next = 1;
      run(1, 32'h0123_4560, 0, 0, 32'h0, '0, 0, 0, ni, nd);
      check("stray_line", i_rdata, exp_line);
      stray_en = 0;

      // reset in the middle of a read
      use_force = 0; base = match_sent;
      @(posedge clk); #1;
      i_read = 1; i_addr = 32'h0aaa_0100;
      n = 0;
      while (match_sent - base < 2 && n < 100) begin @(negedge clk); n++; end
      check("midrst_beats_seen", (match_sent - base) >= 2, 1'b1);
      do_reset(1);
      @(negedge clk);
      check("midrst_bmem_read", bmem_read, 1'b0);
      check("midrst_bmem_addr", bmem_addr, 32'h0);
      check("midrst_resp", {i_resp, d_resp}, 2'b00);
      check("midrst_i_rdata", i_rdata, 256'h0);
      repeat (10) @(negedge clk);
      drain();
      run(1, 32'h0aaa_0200, 0, 0, 32'h0, '0, 0, 0, ni, nd);
      check("midrst_next_latency", ni, 7);

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         int unsigned mode;
         logic [31:0] ia, da;
         mode = $urandom_range(0, 4);
         ready_pct = $urandom_range(50, 100);
         gap_pct = $urandom_range(0, 40);
         stray_en = $urandom_range(0, 1);
         stray_next = 1;
         ia = $urandom & 32'h0fff_ffff;
         da = $urandom & 32'h0fff_ffff;
         for (int w = 0; w < 8; w++) wl[32*w +: 32] = $urandom;
         case (mode)
            0: run(1, ia, 0, 0, da, wl, 0, 0, ni, nd);
            1: run(0, ia, 1, 0, da, wl, 0, 0, ni, nd);
            2: run(0, ia, 0, 1, da, wl, 0, 0, ni, nd);
            3: run(1, ia, 1, 0, da, wl, 0, 0, ni, nd);
            default: run(1, ia, 1'($urandom_range(0, 1)), 1, da, wl, 0, 0, ni, nd);
         endcase
         drain();
      end
      stray_en = 0;
      ready_pct = 100;
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
